// File: rtl/dl_pkg.sv
// Shared definitions for the dl_ stream library: the packet-lock state encoding
// and the select-width helper used to size channel indices.
package dl_pkg;

    typedef enum logic {
        DL_LOCK_IDLE   = 1'b0,
        DL_LOCK_LOCKED = 1'b1
    } dl_lock_e;

    // Width of a channel index. It is never zero, so a single-channel block still has a 1-bit select.
    function automatic int dl_sel_bits(input int n);
        return (n <= 1) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/dl_rr_arbiter.sv
// Combinational round-robin arbiter. It scans req starting at ptr, wraps modulo NUM_IN
// and honours an eligibility mask. Tie mask to all ones when the mask is not needed.
module dl_rr_arbiter
    import dl_pkg::*;
#(
    parameter  int NUM_IN   = 4,
    localparam int SEL_BITS = dl_sel_bits(NUM_IN)
) (
    input  logic [NUM_IN-1:0]   req,
    input  logic [SEL_BITS-1:0] ptr,
    input  logic [NUM_IN-1:0]   mask,
    output logic [NUM_IN-1:0]   grant,
    output logic [SEL_BITS-1:0] grant_idx,
    output logic                any_grant
);

    always_comb begin
        // NOTE: every output is given a default before the loop, so no path leaves it unassigned and no latch is inferred.
        grant     = '0;
        grant_idx = '0;
        any_grant = 1'b0;
        for (int k = 0; k < NUM_IN; k++) begin
            int idx;
            // ptr is always below NUM_IN, so one conditional subtract gives the wrap.
            idx = int'(ptr) + k;
            if (idx >= NUM_IN) idx = idx - NUM_IN;
            if (!any_grant && req[idx] && mask[idx]) begin
                any_grant  = 1'b1;
                grant[idx] = 1'b1;
                grant_idx  = SEL_BITS'(idx);
            end
        end
    end

endmodule

// File: rtl/dl_rr_mux.sv
// N-input round-robin stream mux with a registered output stage.
// Define DL_RR_MUX_LOCK_EN to hold the grant on one channel until it sends its in_last beat.
module dl_rr_mux
    import dl_pkg::*;
#(
    parameter  int NUM_BITS = 32,
    parameter  int NUM_IN   = 4,
    localparam int SEL_BITS = dl_sel_bits(NUM_IN)
) (
    input  logic                             clk,
    input  logic                             rst,
    input  logic [NUM_IN-1:0][NUM_BITS-1:0]  in_data,
    input  logic [NUM_IN-1:0]                in_valid,
    input  logic [NUM_IN-1:0]                in_last,
    output logic [NUM_IN-1:0]                in_ready,
    output logic [NUM_BITS-1:0]              out_data,
    output logic                             out_valid,
    output logic                             out_last,
    output logic [SEL_BITS-1:0]              out_sel,
    input  logic                             out_ready
);

    logic                load;
    logic                any_grant;
    logic [NUM_IN-1:0]   grant;
    logic [NUM_IN-1:0]   elig_mask;
    logic [SEL_BITS-1:0] rr_ptr;
    logic [SEL_BITS-1:0] grant_idx;
    logic [SEL_BITS-1:0] next_ptr;

`ifdef DL_RR_MUX_LOCK_EN
    dl_lock_e            lock_state;
    logic [SEL_BITS-1:0] lock_idx;

    always_comb begin
        elig_mask = '1;
        if (lock_state == DL_LOCK_LOCKED) begin
            elig_mask           = '0;
            elig_mask[lock_idx] = 1'b1;
        end
    end
`else
    assign elig_mask = '1;
`endif

    // The output slot is free when it is empty or being popped this cycle.
    assign load     = !out_valid || out_ready;
    assign in_ready = (load && !rst) ? grant : '0;
    assign next_ptr = (int'(grant_idx) == NUM_IN - 1) ? '0 : grant_idx + SEL_BITS'(1);

    dl_rr_arbiter #(
        .NUM_IN    (NUM_IN)
    ) u_arbiter (
        .req       (in_valid),
        .ptr       (rr_ptr),
        .mask      (elig_mask),
        .grant     (grant),
        .grant_idx (grant_idx),
        .any_grant (any_grant)
    );

    always_ff @(posedge clk) begin
        // NOTE: all state is flopped with non-blocking assignments, and the reset is a synchronous branch of the same block.
        if (rst) begin
            out_valid  <= 1'b0;
            out_data   <= '0;
            out_last   <= 1'b0;
            out_sel    <= '0;
            rr_ptr     <= '0;
`ifdef DL_RR_MUX_LOCK_EN
            lock_state <= DL_LOCK_IDLE;
            lock_idx   <= '0;
`endif
        end else if (load) begin
            if (any_grant) begin
                out_valid <= 1'b1;
                out_data  <= in_data[grant_idx];
                out_last  <= in_last[grant_idx];
                out_sel   <= grant_idx;
`ifdef DL_RR_MUX_LOCK_EN
                if (lock_state == DL_LOCK_IDLE) begin
                    rr_ptr <= next_ptr;
                    if (!in_last[grant_idx]) begin
                        lock_state <= DL_LOCK_LOCKED;
                        lock_idx   <= grant_idx;
                    end
                end else if (in_last[grant_idx]) begin
                    // Only lock_idx can be granted while locked, so next_ptr is lock_idx+1 here.
                    lock_state <= DL_LOCK_IDLE;
                    rr_ptr     <= next_ptr;
                end
`else
                rr_ptr <= next_ptr;
`endif
            end else begin
                out_valid <= 1'b0;
            end
        end
    end

endmodule

// File: doc/dl_rr_mux.md
# dl_rr_mux

Parametrised N-input stream multiplexer with valid/ready handshaking, round-robin arbitration and a registered output stage. It is the next generation of the design library's fixed two-input mux: it selects among many producers itself, instead of taking an external select, and decouples producer and consumer timing with a one-cycle output register. It is intended for merging request streams inside the core, such as memory-request merge and writeback-port sharing.

## Interface
- NUM_BITS, default 32: payload width per channel.
- NUM_IN, default 4: number of input channels, at least 1.
- SEL_BITS, localparam: max(1, $clog2(NUM_IN)).

- clk  input  1  rising-edge clock.
- rst  input  1  synchronous, active-high reset.
- in_data  input  [NUM_IN-1:0][NUM_BITS-1:0]  per-channel payload.
- in_valid  input  [NUM_IN-1:0]  per-channel valid.
- in_last  input  [NUM_IN-1:0]  per-channel end-of-packet marker.
- in_ready  output  [NUM_IN-1:0]  per-channel ready, combinational.
- out_data  output  NUM_BITS  registered payload.
- out_valid  output  1  registered valid.
- out_last  output  1  registered last.
- out_sel  output  SEL_BITS  index of the channel that supplied the current output beat.
- out_ready  input  1  consumer ready.

## Operation
- Registered state:
  - rr_ptr (SEL_BITS bits): the highest-priority channel.
  - Output registers.
  - Lock FSM: present only with the macro.
- Load condition: load = !out_valid || out_ready.
- Grant: the first channel i with in_valid[i], scanning rr_ptr, rr_ptr+1, … with wrap modulo NUM_IN.
  - Wrap is modulo NUM_IN, so non-power-of-2 NUM_IN never indexes past NUM_IN-1.
- in_ready[g] = load && (g is granted) && !rst. Every other bit of in_ready is 0.
  - At most one in_ready bit is high in any cycle.
- Transfer on channel g (in_valid[g] && in_ready[g]):
  - out_data, out_last and out_sel load from channel g.
  - out_valid ← 1.
  - rr_ptr ← (g+1) mod NUM_IN, unless lock (see Configuration) holds it.
- load with no valid input: out_valid ← 0; the data registers hold.
- !load (output stalled): all registers hold. No input is accepted.
- in_valid dropping without a transfer is legal. The grant re-evaluates every cycle.
- in_data from a granted but unaccepted channel is never sampled.
- Fairness: with all channels continuously valid and out_ready=1, grants cycle 0,1,…,NUM_IN-1,0,…
- NUM_IN=1: the grant is always channel 0 and rr_ptr stays 0.

## Timing
- Latency: an input accepted in cycle t appears on out_* in cycle t+1.
- Throughput: one beat per cycle when out_ready is held high. Simultaneous pop and push in the same cycle is supported.
- Combinational path: out_ready → in_ready. There is no path from in_valid to out_*.
- Reset values:
  - out_valid = 0, out_data = 0, out_last = 0, out_sel = 0.
  - rr_ptr = 0; lock FSM = IDLE.
  - in_ready = 0 while rst is high.
- Reset mid-transfer: the beat in the output register is discarded, nothing is accepted in the reset cycle, and the lock is released.

## Configuration
- Macro: DL_RR_MUX_LOCK_EN.
- Defined: packet lock.
  - FSM states:
    - IDLE: normal round-robin arbitration.
    - LOCKED(lock_idx): only lock_idx is eligible.
  - IDLE → LOCKED(g) on a transfer from g with in_last[g]=0.
  - LOCKED → IDLE on a transfer from lock_idx with in_last=1; rr_ptr ← lock_idx+1 at that point.
  - rr_ptr does not change while LOCKED.
  - Other channels wait indefinitely while the locked channel is not valid.
- Not defined: in_last is passed through to out_last only. Arbitration is per beat and no FSM is instantiated.

## Structure
- Shared package dl_pkg holds:
  - the lock-state enum typedef (DL_LOCK_IDLE, DL_LOCK_LOCKED);
  - a function computing max(1, $clog2(n)).
- Sub-module dl_rr_arbiter: combinational, parametrised by NUM_IN.
  - Inputs: req vector, ptr, optional mask.
  - Outputs: one-hot grant, grant index, any_grant.
  - Intended for reuse by other arbitrated blocks.
- dl_rr_mux holds the output registers, rr_ptr, the lock FSM and the ready gating.

## Test plan
- NUM_IN=4, all valid, out_ready=1, payload = channel index → out_sel sequence 0,1,2,3,0,1 with out_valid high every cycle.
- Only channel 2 valid from reset → first output is channel 2 data one cycle after acceptance. Next, channels 0 and 3 both valid → channel 3 wins (rr_ptr=3), then channel 0.
- Backpressure: out_ready=0 for 3 cycles with out_valid=1 → out_data stable, all in_ready=0. On release, the next beat is accepted in the same cycle as the pop.
- NUM_IN=3 wrap: grant from channel 2 → rr_ptr=0. Check no out-of-range out_sel over 1000 random cycles. Per-channel data order must be preserved in a scoreboard.
- Lock (macro defined): channel 1 sends beats with last=0,0,1 while channel 2 stays valid → out_sel=1,1,1, then 2. Macro undefined → interleaved 1,2,1,2.
- Assert rst mid-packet with out_valid=1 → next cycle out_valid=0, out_data=0, in_ready=0. After release, arbitration restarts from channel 0 in IDLE.
